// File: rtl/gas_scan_scheduler.sv
// Purpose: time-multiplex one serial gas-decoding engine across N sensor channels, latch per-channel levels, track scan max and a debounced alarm.
// Latency: each enabled channel costs FRAME_LEN+2 cycles (flush, listen, capture); results register on the edge leaving SCAN_END.
// Backpressure: none; the engine is free-running and is sampled only in CAPTURE, so the schedule never stalls.
module gas_scan_scheduler #(
    parameter int         N         = 4,
    parameter int         FRAME_LEN = 8,
    parameter logic [2:0] ALARM_TH  = 3'd4,
    parameter int         CONFIRM   = 2
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [N-1:0]     ch_en,
    input  logic [N-1:0]     ch_din,
    output logic             eng_din,
    output logic             eng_rst,
    input  logic [2:0]       eng_dout,
    output logic [3*N-1:0]   level_bus,
    output logic [2:0]       max_level,
    output logic [2:0]       max_ch,
    output logic             alarm,
    output logic             scan_done
);

    localparam int             SW      = (N > 1) ? $clog2(N) : 1;
    localparam int             WW      = $clog2(FRAME_LEN);
    localparam logic [WW-1:0]  WLAST   = WW'(FRAME_LEN - 1);
    localparam logic [2:0]     CONF3   = 3'(CONFIRM);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        LISTEN,
        CAPTURE,
        SCAN_END
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       sel_q, sel_d;
    logic [WW-1:0]       wcnt_q, wcnt_d;
    logic [N-1:0]        visited_q;
    logic [N-1:0][2:0]   lvl_q;
    logic [2:0]          hi_cnt_q, lo_cnt_q;
    logic [2:0]          max_level_q, max_ch_q;
    logic                alarm_q, scan_done_q, eng_rst_q;

    // search results
    logic [SW-1:0]       first_idx, nxt_idx, vis_first, mx_ch;
    logic                first_found, nxt_found, vis_found, mx_found;
    logic [2:0]          mx_lvl;
    logic [N-1:0]        cand;
    logic [2:0]          hi_inc, lo_inc;
    logic                is_high;

    // Channels that count toward the max: visited this scan and still enabled now.
    assign cand = visited_q & ch_en;

    // Priority searches: first enabled, next enabled after sel, first visited, and lowest-index max.
    always_comb begin
        first_idx   = '0;
        first_found = 1'b0;
        nxt_idx     = '0;
        nxt_found   = 1'b0;
        vis_first   = '0;
        vis_found   = 1'b0;
        mx_lvl      = '0;
        mx_ch       = '0;
        mx_found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!first_found && ch_en[i]) begin
                first_idx   = SW'(i);
                first_found = 1'b1;
            end
            if (!nxt_found && ch_en[i] && (SW'(i) > sel_q)) begin
                nxt_idx   = SW'(i);
                nxt_found = 1'b1;
            end
            if (!vis_found && visited_q[i]) begin
                vis_first = SW'(i);
                vis_found = 1'b1;
            end
            // strict > keeps the lowest index on ties
            if (cand[i] && (!mx_found || (lvl_q[i] > mx_lvl))) begin
                mx_lvl   = lvl_q[i];
                mx_ch    = SW'(i);
                mx_found = 1'b1;
            end
        end
        // nothing qualifies: report level 0 at the first visited channel
        if (!mx_found) begin
            mx_ch = vis_first;
        end
    end

    // Saturating debounce increments and the high/low classification of this scan.
    always_comb begin
        hi_inc  = (hi_cnt_q == 3'd7) ? 3'd7 : hi_cnt_q + 3'd1;
        lo_inc  = (lo_cnt_q == 3'd7) ? 3'd7 : lo_cnt_q + 3'd1;
        is_high = (mx_lvl >= ALARM_TH);
    end

    // Next-state logic for the scan sequencer.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (first_found) begin
                    sel_d   = first_idx;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                wcnt_d  = '0;
                state_d = LISTEN;
            end
            LISTEN: begin
                if (wcnt_q == WLAST) begin
                    state_d = CAPTURE;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            CAPTURE: begin
                if (nxt_found) begin
                    sel_d   = nxt_idx;
                    state_d = FLUSH;
                end else begin
                    state_d = SCAN_END;
                end
            end
            SCAN_END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (!arst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Engine reset is high exactly during FLUSH; results, alarm debounce and scan_done update at capture/scan end.
    always_ff @(posedge clk) begin
        if (!arst) begin
            eng_rst_q   <= 1'b1;
            visited_q   <= '0;
            lvl_q       <= '0;
            hi_cnt_q    <= '0;
            lo_cnt_q    <= '0;
            max_level_q <= '0;
            max_ch_q    <= '0;
            alarm_q     <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            eng_rst_q   <= (state_d == FLUSH);
            scan_done_q <= (state_q == SCAN_END);
            if (state_q == CAPTURE) begin
                lvl_q[sel_q]     <= eng_dout;
                visited_q[sel_q] <= 1'b1;
            end
            if (state_q == SCAN_END) begin
                for (int i = 0; i < N; i++) begin
                    if (!ch_en[i]) begin
                        lvl_q[i] <= '0;
                    end
                end
                visited_q   <= '0;
                max_level_q <= mx_lvl;
                max_ch_q    <= 3'(mx_ch);
                if (is_high) begin
                    hi_cnt_q <= hi_inc;
                    lo_cnt_q <= '0;
                    if (hi_inc >= CONF3) begin
                        alarm_q <= 1'b1;
                    end
                end else begin
                    lo_cnt_q <= lo_inc;
                    hi_cnt_q <= '0;
                    if (lo_inc >= CONF3) begin
                        alarm_q <= 1'b0;
                    end
                end
            end
        end
    end

    // The serial bit is muxed straight through while listening, otherwise held low.
    assign eng_din   = (state_q == LISTEN) ? ch_din[sel_q] : 1'b0;
    assign eng_rst   = eng_rst_q;
    assign level_bus = lvl_q;
    assign max_level = max_level_q;
    assign max_ch    = max_ch_q;
    assign alarm     = alarm_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_gas_scan_scheduler.sv
// Purpose: self-checking bench for gas_scan_scheduler with a ones-counting engine model and a schedule-level reference.
// Latency: checks every cycle of each scan plus the registered results in the cycle after SCAN_END.
// Backpressure: not applicable; stimulus is driven open-loop.
module tb_gas_scan_scheduler;

    localparam int         N    = 4;
    localparam int         FL   = 8;
    localparam int         CONF = 2;
    localparam logic [2:0] TH   = 3'd4;
    localparam int         SLOT = FL + 2;

    logic           clk = 1'b0;
    logic           arst;
    logic [N-1:0]   ch_en;
    logic [N-1:0]   ch_din;
    logic           eng_din;
    logic           eng_rst;
    logic [2:0]     eng_dout;
    logic [3*N-1:0] level_bus;
    logic [2:0]     max_level;
    logic [2:0]     max_ch;
    logic           alarm;
    logic           scan_done;

    always #5 clk = ~clk;

    gas_scan_scheduler #(
        .N(N), .FRAME_LEN(FL), .ALARM_TH(TH), .CONFIRM(CONF)
    ) dut (
        .clk(clk), .arst(arst), .ch_en(ch_en), .ch_din(ch_din),
        .eng_din(eng_din), .eng_rst(eng_rst), .eng_dout(eng_dout),
        .level_bus(level_bus), .max_level(max_level), .max_ch(max_ch),
        .alarm(alarm), .scan_done(scan_done)
    );

    // Engine model: level = number of 1 bits seen since its reset, saturating at 7.
    logic [2:0] eng_cnt;
    always @(posedge clk) begin
        if (eng_rst) eng_cnt <= 3'd0;
        else if (eng_din && eng_cnt != 3'd7) eng_cnt <= eng_cnt + 3'd1;
    end
    assign eng_dout = eng_cnt;

    int   total = 0;
    int   bad   = 0;
    int   exp_lvl [N];
    int   exp_max;
    int   exp_maxch;
    logic exp_alarm;
    bit   hist [$];
    logic rst_pending;
    int   alarm_seq [8] = '{4, 3, 4, 4, 2, 5, 1, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_above(input logic [N-1:0] m, input int after);
        for (int i = after + 1; i < N; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic logic [4*N-1:0] rand_lv();
        logic [4*N-1:0] lv;
        for (int i = 0; i < N; i++) lv[4*i +: 4] = 4'($urandom_range(8));
        return lv;
    endfunction

    task automatic do_reset(input int n);
        arst = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_eng_rst",   32'(eng_rst),   32'd1);
        chk("rst_eng_din",   32'(eng_din),   32'd0);
        chk("rst_level_bus", 32'(level_bus), 32'd0);
        chk("rst_max_level", 32'(max_level), 32'd0);
        chk("rst_max_ch",    32'(max_ch),    32'd0);
        chk("rst_alarm",     32'(alarm),     32'd0);
        chk("rst_scan_done", 32'(scan_done), 32'd0);
        for (int i = 0; i < N; i++) exp_lvl[i] = 0;
        exp_max     = 0;
        exp_maxch   = 0;
        exp_alarm   = 1'b0;
        hist.delete();
        rst_pending = 1'b1;
        arst        = 1'b1;
    endtask

    // One scan starting in the IDLE cycle: mask en_a, switching to en_b from cycle sw_c on.
    // lv holds the number of 1 bits each channel sends during its own window.
    task automatic run_scan(input logic [N-1:0] en_a, input logic [N-1:0] en_b, input int sw_c,
                            input logic [4*N-1:0] lv, input int rst_at);
        int q [$];
        int ones [N];
        bit vis [N];
        int cur, k, tlen, j, off, ch, need, r, mrem;
        logic [N-1:0] m, v;
        logic b, listening, found, all_hi, all_lo;
        logic [3*N-1:0] exp_bus;

        // visiting order from the mask seen at IDLE and at each capture
        m   = (sw_c <= 0) ? en_b : en_a;
        cur = lowest_above(m, -1);
        while (cur >= 0) begin
            q.push_back(cur);
            m   = (SLOT * q.size() >= sw_c) ? en_b : en_a;
            cur = lowest_above(m, cur);
        end
        k = q.size();
        if (k == 0) return;
        tlen = 1 + k * SLOT + 1;
        for (int i = 0; i < N; i++) begin
            ones[i] = 0;
            vis[i]  = 1'b0;
        end
        foreach (q[i]) vis[q[i]] = 1'b1;

        for (int c = 0; c < tlen; c++) begin
            m         = (c >= sw_c) ? en_b : en_a;
            v         = N'($urandom);
            listening = 1'b0;
            ch        = 0;
            off       = -1;
            if (c >= 1 && c <= k * SLOT) begin
                j   = (c - 1) / SLOT;
                off = (c - 1) % SLOT;
                ch  = q[j];
                if (off >= 1 && off <= FL) begin
                    listening = 1'b1;
                    need = int'(lv[4*ch +: 4]);
                    if (need > FL) need = FL;
                    r    = need - ones[ch];
                    mrem = FL - off + 1;
                    b    = (int'($urandom_range(mrem - 1)) < r);
                    v[ch] = b;
                    ones[ch] += int'(b);
                end
            end
            ch_en  = m;
            ch_din = v;
            if (c == rst_at) begin
                do_reset(1);
                return;
            end
            #1;
            chk("eng_rst", 32'(eng_rst), (c == 0) ? 32'(rst_pending) : 32'(off == 0));
            if (c == 0 || listening) chk("eng_din", 32'(eng_din), listening ? 32'(v[ch]) : 32'd0);
            if (c >= 1) chk("scan_done_low", 32'(scan_done), 32'd0);
            rst_pending = 1'b0;
            @(posedge clk);
            #1;
        end

        // results: disabled slots clear, visited enabled slots take the window's count
        m = (tlen - 1 >= sw_c) ? en_b : en_a;
        for (int i = 0; i < N; i++) begin
            if (!m[i]) exp_lvl[i] = 0;
            else if (vis[i]) exp_lvl[i] = (ones[i] > 7) ? 7 : ones[i];
        end
        exp_max   = 0;
        exp_maxch = q[0];
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vis[i] && m[i] && (!found || exp_lvl[i] > exp_max)) begin
                exp_max   = exp_lvl[i];
                exp_maxch = i;
                found     = 1'b1;
            end
        end
        hist.push_back(exp_max >= int'(TH));
        if (hist.size() >= CONF) begin
            all_hi = 1'b1;
            all_lo = 1'b1;
            for (int i = hist.size() - CONF; i < hist.size(); i++) begin
                if (hist[i]) all_lo = 1'b0;
                else all_hi = 1'b0;
            end
            if (all_hi) exp_alarm = 1'b1;
            if (all_lo) exp_alarm = 1'b0;
        end
        for (int i = 0; i < N; i++) exp_bus[3*i +: 3] = 3'(exp_lvl[i]);
        chk("scan_done_pulse", 32'(scan_done), 32'd1);
        chk("max_level",       32'(max_level), 32'(exp_max));
        chk("max_ch",          32'(max_ch),    32'(exp_maxch));
        chk("alarm",           32'(alarm),     32'(exp_alarm));
        chk("level_bus",       32'(level_bus), 32'(exp_bus));
    endtask

    initial begin
        logic [N-1:0] ea, eb;
        int sw, la, lb;
        arst        = 1'b0;
        ch_en       = '0;
        ch_din      = '0;
        rst_pending = 1'b0;
        do_reset(3);

        // single channel, level 5: alarm rises with the second scan
        run_scan(4'b0001, 4'b0001, 1000, {4'd0, 4'd0, 4'd0, 4'd5}, -1);
        run_scan(4'b0001, 4'b0001, 1000, {4'd0, 4'd0, 4'd0, 4'd5}, -1);

        // all enabled, levels 1/6/6/2: max 6 at channel 1
        run_scan(4'b1111, 4'b1111, 1000, {4'd2, 4'd6, 4'd6, 4'd1}, -1);

        // alarm hysteresis from a fresh reset
        do_reset(2);
        for (int s = 0; s < 8; s++) begin
            la = alarm_seq[s];
            lb = int'($urandom_range(la));
            run_scan(4'b0011, 4'b0011, 1000, {4'd0, 4'd0, 4'(lb), 4'(la)}, -1);
        end

        // empty mask: engine never reset, no scans
        for (int c = 0; c < 100; c++) begin
            ch_en  = '0;
            ch_din = N'($urandom);
            #1;
            chk("idle_eng_din", 32'(eng_din), 32'd0);
            @(posedge clk);
            #1;
            chk("idle_eng_rst",   32'(eng_rst),   32'd0);
            chk("idle_scan_done", 32'(scan_done), 32'd0);
        end

        // mask drops to 1010 during channel 0's window
        run_scan(4'b1111, 4'b1010, 4, rand_lv(), -1);

        // reset during channel 2's window, then a clean scan
        run_scan(4'b1111, 4'b1111, 1000, rand_lv(), 1 + 2 * SLOT + 4);
        run_scan(4'b1111, 4'b1111, 1000, rand_lv(), -1);

        // randomized masks, mid-scan mask changes and levels
        for (int s = 0; s < 40; s++) begin
            ea = N'($urandom_range(1, (1 << N) - 1));
            eb = (($urandom_range(3)) == 0) ? N'($urandom) : ea;
            sw = int'($urandom_range(1, 50));
            run_scan(ea, eb, sw, rand_lv(), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
